// File: rtl/change_event_tx.sv
`default_nettype none
// ============================================================================
// Module      : change_event_tx
// Description : Queues detector change events and reports each one as a
//               two-byte UART 8N1 frame (header 0xA0|chan, then data byte).
// Revision    : 1.0 - initial release
// ============================================================================
module change_event_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       evt_valid,
    input  logic [1:0] evt_chan,
    input  logic [7:0] evt_data,
    input  logic       ovf_clr,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);
    localparam logic [15:0]        c_last_baud = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          baud_q, baud_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 byte_sel_q, byte_sel_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 full_q, full_d;
    logic                 ovf_q, ovf_d;
    logic [9:0]           mem_q [FIFO_DEPTH];

    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_baud_done;
    logic [9:0]           w_head;

    always_comb begin
        w_head      = mem_q[rd_ptr_q];
        w_baud_done = (baud_q == c_last_baud);
        w_pop       = (state_q == IDLE) && (count_q != '0);
        // A full FIFO still accepts when the head leaves in the same cycle.
        w_push      = evt_valid && ((count_q != c_depth) || w_pop);
        w_drop      = evt_valid && !w_push;
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        byte_sel_d = byte_sel_q;
        case (state_q)
            IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                if (w_pop) begin
                    shift_d    = {4'hA, 2'b00, w_head[9:8]};
                    data_d     = w_head[7:0];
                    byte_sel_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    baud_d = '0;
                    if (!byte_sel_q) begin
                        shift_d    = data_q;
                        byte_sel_d = 1'b1;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx follows the current state one cycle late, so it falls two edges after the push.
    always_comb begin
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == c_depth);
        ovf_d  = w_drop | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            byte_sel_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            byte_sel_q <= byte_sel_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {evt_chan, evt_data};
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign fifo_full = full_q;
    assign overflow  = ovf_q;

endmodule
`default_nettype wire
